// File: rtl/jpeg_encoder_top.sv
// Streaming luma encoder front end: RGB -> Y, 64-pixel block DC, DPCM plus
// luminance DC Huffman coding, followed by an EOB word for each block.
module jpeg_encoder_top #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  R,
    input  logic [7:0]  G,
    input  logic [7:0]  B,
    output logic [15:0] out_code,
    output logic [3:0]  out_len,
    output logic        out_valid,
    output logic        img_done
);

    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W = $clog2(TOTAL);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(TOTAL - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic             take_pixel;
    logic [CNT_W-1:0] pix_cnt;

    // Pixel capture stage
    logic       s1_valid, s1_first, s1_last, s1_frame_end;
    logic [7:0] s1_r, s1_g, s1_b;

    // Luma stage
    logic        s2_valid, s2_first, s2_last, s2_frame_end;
    logic [7:0]  s2_y;
    logic [15:0] luma_sum;

    // Accumulation stage
    logic               s3_done, s3_frame_end;
    logic signed [13:0] acc;
    logic signed [13:0] acc_base;
    logic signed [8:0]  y_c;

    // Coding stage
    logic signed [7:0] pred;
    logic signed [7:0] dc;
    logic signed [8:0] diff;
    logic [7:0]        mag;
    logic [7:0]        amp_src;
    logic [7:0]        amp_mask;
    logic [3:0]        cat;
    logic [5:0]        huff_code;
    logic [3:0]        huff_len;
    logic [15:0]       dc_code;
    logic [3:0]        dc_len;
    logic              eob_pending, eob_last;

    // ------------------------------------------------------------------
    // Frame control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a
        // variable unassigned and infers a latch.
        state_next = state;
        take_pixel = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                if (start) begin
                    state_next = RUN;
                end else begin
                    take_pixel = 1'b1;
                    if (pix_cnt == LAST_PIX) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          pix_cnt <= '0;
        else if (start)      pix_cnt <= '0;
        else if (take_pixel) pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
    end

    // ------------------------------------------------------------------
    // Stage 1: sample pixel and block-position flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_first     <= 1'b0;
            s1_last      <= 1'b0;
            s1_frame_end <= 1'b0;
            s1_r         <= '0;
            s1_g         <= '0;
            s1_b         <= '0;
        end else begin
            s1_valid <= take_pixel;
            if (take_pixel) begin
                s1_first     <= (pix_cnt[5:0] == 6'd0);
                s1_last      <= (pix_cnt[5:0] == 6'd63);
                s1_frame_end <= (pix_cnt == LAST_PIX);
                s1_r         <= R;
                s1_g         <= G;
                s1_b         <= B;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: luma
    // ------------------------------------------------------------------
    assign luma_sum = 16'd77  * {8'd0, s1_r}
                    + 16'd150 * {8'd0, s1_g}
                    + 16'd29  * {8'd0, s1_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid     <= 1'b0;
            s2_first     <= 1'b0;
            s2_last      <= 1'b0;
            s2_frame_end <= 1'b0;
            s2_y         <= '0;
        end else begin
            s2_valid     <= s1_valid & ~start;
            s2_first     <= s1_first;
            s2_last      <= s1_last;
            s2_frame_end <= s1_frame_end;
            s2_y         <= 8'(luma_sum >> 8);
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: block accumulation of level-shifted luma
    // ------------------------------------------------------------------
    assign y_c      = $signed({1'b0, s2_y}) - 9'sd128;
    assign acc_base = s2_first ? 14'sd0 : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            s3_done      <= 1'b0;
            s3_frame_end <= 1'b0;
        end else if (start) begin
            acc          <= '0;
            s3_done      <= 1'b0;
            s3_frame_end <= 1'b0;
        end else begin
            s3_done      <= s2_valid & s2_last;
            s3_frame_end <= s2_frame_end;
            if (s2_valid) acc <= acc_base + {{5{y_c[8]}}, y_c};
        end
    end

    // ------------------------------------------------------------------
    // Stage 4: DPCM, category, amplitude and Huffman code
    // ------------------------------------------------------------------
    assign dc = 8'(acc >>> 6);

    always_comb begin
        diff      = {dc[7], dc} - {pred[7], pred};
        mag       = diff[8] ? 8'(-diff) : diff[7:0];
        amp_src   = diff[8] ? 8'(diff - 9'sd1) : diff[7:0];
        cat       = 4'd0;
        huff_code = 6'b0;
        huff_len  = 4'd2;
        for (int i = 0; i < 8; i++) begin
            if (mag[i]) cat = 4'(i + 1);
        end
        amp_mask = ~(8'hFF << cat);
        case (cat)
            4'd0:    begin huff_code = 6'b000000; huff_len = 4'd2; end
            4'd1:    begin huff_code = 6'b000010; huff_len = 4'd3; end
            4'd2:    begin huff_code = 6'b000011; huff_len = 4'd3; end
            4'd3:    begin huff_code = 6'b000100; huff_len = 4'd3; end
            4'd4:    begin huff_code = 6'b000101; huff_len = 4'd3; end
            4'd5:    begin huff_code = 6'b000110; huff_len = 4'd3; end
            4'd6:    begin huff_code = 6'b001110; huff_len = 4'd4; end
            4'd7:    begin huff_code = 6'b011110; huff_len = 4'd5; end
            default: begin huff_code = 6'b111110; huff_len = 4'd6; end
        endcase
        dc_code = ({10'd0, huff_code} << cat) | {8'd0, amp_src & amp_mask};
        dc_len  = huff_len + cat;
    end

    // DC word first, EOB word on the following cycle; outputs hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_code    <= '0;
            out_len     <= '0;
            out_valid   <= 1'b0;
            img_done    <= 1'b0;
            pred        <= '0;
            eob_pending <= 1'b0;
            eob_last    <= 1'b0;
        end else if (start) begin
            out_valid   <= 1'b0;
            img_done    <= 1'b0;
            pred        <= '0;
            eob_pending <= 1'b0;
            eob_last    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (s3_done) begin
                out_code    <= dc_code;
                out_len     <= dc_len;
                out_valid   <= 1'b1;
                pred        <= dc;
                eob_pending <= 1'b1;
                eob_last    <= s3_frame_end;
            end else if (eob_pending) begin
                out_code    <= 16'h000A;
                out_len     <= 4'd4;
                out_valid   <= 1'b1;
                eob_pending <= 1'b0;
                if (eob_last) img_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jpeg_encoder_top.sv
// Bench for jpeg_encoder_top: whole frames are driven from a pixel array and
// the emitted word stream is compared with a block-level arithmetic model.
module tb_jpeg_encoder_top;

    localparam int W    = 64;
    localparam int H    = 64;
    localparam int NPIX = W * H;
    localparam int NBLK = NPIX / 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic [15:0] out_code;
    logic [3:0]  out_len;
    logic        out_valid;
    logic        img_done;

    jpeg_encoder_top #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .R(r), .G(g), .B(b),
        .out_code(out_code), .out_len(out_len),
        .out_valid(out_valid), .img_done(img_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int code;
        int len;
        bit done;
    } word_t;

    word_t       rx[$];
    word_t       ex[$];
    word_t       mon_w;
    logic [23:0] pix[NPIX];
    int          n_assert = 0;
    int          n_fail = 0;

    always @(negedge clk) begin
        if (out_valid) begin
            mon_w.code = int'(out_code);
            mon_w.len  = int'(out_len);
            mon_w.done = img_done;
            rx.push_back(mon_w);
        end
    end

    function automatic int rx_code(input int i);
        return (i < rx.size()) ? rx[i].code : -1;
    endfunction

    function automatic int rx_len(input int i);
        return (i < rx.size()) ? rx[i].len : -1;
    endfunction

    task automatic fill(input int mode);
        logic [23:0] c;
        c = '0;
        for (int i = 0; i < NPIX; i++) begin
            case (mode)
                0: pix[i] = 24'hAABBCC;
                1: pix[i] = 24'h000000;
                2: pix[i] = 24'hFFFFFF;
                3: pix[i] = 24'h808080;
                4: pix[i] = ((i / 64) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
                5: pix[i] = 24'($urandom);
                default: begin
                    if (i % 64 == 0) c = 24'($urandom);
                    pix[i] = c;
                end
            endcase
        end
    endtask

    // Reference: per block, mean level-shifted luma -> floor /64 -> DPCM -> JPEG DC code.
    function automatic void build_expected();
        int hcode[9] = '{0, 2, 3, 4, 5, 6, 14, 30, 62};
        int hlen[9]  = '{2, 3, 3, 3, 3, 3, 4, 5, 6};
        int pred, s, y, dc, diff, mag, cat, amp;
        logic [23:0] p;
        word_t w;
        pred = 0;
        ex.delete();
        for (int blk = 0; blk < NBLK; blk++) begin
            s = 0;
            for (int k = 0; k < 64; k++) begin
                p = pix[blk * 64 + k];
                y = (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
                s = s + (y - 128);
            end
            dc   = (s >= 0) ? s / 64 : -((-s + 63) / 64);
            diff = dc - pred;
            mag  = (diff < 0) ? -diff : diff;
            cat  = 0;
            while ((mag >> cat) != 0) cat++;
            amp    = ((diff > 0) ? diff : diff - 1) & ((1 << cat) - 1);
            w.code = (hcode[cat] << cat) | amp;
            w.len  = hlen[cat] + cat;
            w.done = 1'b0;
            ex.push_back(w);
            w.code = 10;
            w.len  = 4;
            w.done = (blk == NBLK - 1);
            ex.push_back(w);
            pred = dc;
        end
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
    endtask

    task automatic drive_pixels(input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            @(negedge clk);
            start = 1'b0;
            {r, g, b} = pix[i];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_assert++;
        if (out_code !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_code: got %h expected 0000", out_code);
        end
        n_assert++;
        if (out_len !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_len: got %0d expected 0", out_len);
        end
        n_assert++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        n_assert++;
        if (img_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %b expected 0", img_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pattern(input int mode, input string name);
        int n;
        fill(mode);
        build_expected();
        rx.delete();
        pulse_start();
        drive_pixels(0, NPIX);
        repeat (8) @(negedge clk);
        n_assert++;
        if (rx.size() != ex.size()) begin
            n_fail++;
            $display("FAIL %s word_count: got %0d expected %0d", name, rx.size(), ex.size());
        end
        n = (rx.size() < ex.size()) ? rx.size() : ex.size();
        for (int i = 0; i < n; i++) begin
            n_assert++;
            if (rx[i].code != ex[i].code || rx[i].len != ex[i].len || rx[i].done != ex[i].done) begin
                n_fail++;
                $display("FAIL %s word %0d: got code=%h len=%0d done=%0b expected code=%h len=%0d done=%0b",
                         name, i, rx[i].code, rx[i].len, rx[i].done, ex[i].code, ex[i].len, ex[i].done);
            end
        end
    endtask

    task automatic test_constant();
        test_pattern(0, "const_aabbcc");
        n_assert++;
        if (rx_code(0) != 'h03B7 || rx_len(0) != 10) begin
            n_fail++;
            $display("FAIL const_first_dc: got %h/%0d expected 03b7/10", rx_code(0), rx_len(0));
        end
        n_assert++;
        if (rx_code(1) != 'h000A || rx_len(1) != 4) begin
            n_fail++;
            $display("FAIL const_first_eob: got %h/%0d expected 000a/4", rx_code(1), rx_len(1));
        end
        n_assert++;
        if (rx_code(2) != 0 || rx_len(2) != 2) begin
            n_fail++;
            $display("FAIL const_second_dc: got %h/%0d expected 0000/2", rx_code(2), rx_len(2));
        end
        n_assert++;
        if (rx.size() != 128) begin
            n_fail++;
            $display("FAIL const_count: got %0d expected 128", rx.size());
        end
        repeat (20) @(negedge clk);
        n_assert++;
        if (img_done !== 1'b1) begin
            n_fail++;
            $display("FAIL const_done_sticky: got %b expected 1", img_done);
        end
    endtask

    task automatic test_extremes();
        test_pattern(1, "all_black");
        n_assert++;
        if (rx_code(0) != 'h3E7F || rx_len(0) != 14) begin
            n_fail++;
            $display("FAIL black_first_dc: got %h/%0d expected 3e7f/14", rx_code(0), rx_len(0));
        end
        test_pattern(2, "all_white");
        n_assert++;
        if (rx_code(0) != 'h0F7F || rx_len(0) != 12) begin
            n_fail++;
            $display("FAIL white_first_dc: got %h/%0d expected 0f7f/12", rx_code(0), rx_len(0));
        end
        test_pattern(3, "all_mid");
        for (int i = 0; i < rx.size(); i += 2) begin
            n_assert++;
            if (rx[i].code != 0 || rx[i].len != 2) begin
                n_fail++;
                $display("FAIL mid_dc word %0d: got %h/%0d expected 0000/2", i, rx[i].code, rx[i].len);
            end
        end
    endtask

    task automatic test_alternating();
        test_pattern(4, "alternating");
        n_assert++;
        if (rx_code(2) != 'h3EFF || rx_len(2) != 14) begin
            n_fail++;
            $display("FAIL alt_plus255: got %h/%0d expected 3eff/14", rx_code(2), rx_len(2));
        end
        n_assert++;
        if (rx_code(4) != 'h3E00 || rx_len(4) != 14) begin
            n_fail++;
            $display("FAIL alt_minus255: got %h/%0d expected 3e00/14", rx_code(4), rx_len(4));
        end
    endtask

    task automatic test_random();
        test_pattern(5, "random_pixels");
        test_pattern(6, "random_blocks");
    endtask

    task automatic test_restart();
        int n;
        fill(6);
        build_expected();
        rx.delete();
        pulse_start();
        drive_pixels(0, 100);
        n_assert++;
        if (img_done !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_done_cleared: got %b expected 0", img_done);
        end
        rx.delete();
        pulse_start();
        drive_pixels(0, NPIX);
        repeat (8) @(negedge clk);
        n_assert++;
        if (rx.size() != ex.size()) begin
            n_fail++;
            $display("FAIL restart word_count: got %0d expected %0d", rx.size(), ex.size());
        end
        n = (rx.size() < ex.size()) ? rx.size() : ex.size();
        for (int i = 0; i < n; i++) begin
            n_assert++;
            if (rx[i].code != ex[i].code || rx[i].len != ex[i].len || rx[i].done != ex[i].done) begin
                n_fail++;
                $display("FAIL restart word %0d: got code=%h len=%0d done=%0b expected code=%h len=%0d done=%0b",
                         i, rx[i].code, rx[i].len, rx[i].done, ex[i].code, ex[i].len, ex[i].done);
            end
        end
    endtask

    task automatic test_reset_mid();
        fill(5);
        rx.delete();
        pulse_start();
        drive_pixels(0, 200);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_assert++;
        if (out_code !== 16'h0000 || out_len !== 4'd0 || out_valid !== 1'b0 || img_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got code=%h len=%0d valid=%b done=%b expected all 0",
                     out_code, out_len, out_valid, img_done);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rx.delete();
        drive_pixels(200, 300);
        repeat (8) @(negedge clk);
        n_assert++;
        if (rx.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_no_words: got %0d words expected 0", rx.size());
        end
        n_assert++;
        if (img_done !== 1'b0 || out_len !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset_idle: got done=%b len=%0d expected 0/0", img_done, out_len);
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_extremes();
        test_alternating();
        test_random();
        test_restart();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/jpeg_encoder_top.md
# jpeg_encoder_top

Streaming baseline-JPEG-style luma encoder front end. It accepts one RGB pixel per clock after a `start` pulse and converts each pixel to luma (Y). Each group of 64 consecutive pixels is treated as one block, reduced to a quantized DC coefficient, and DPCM plus Huffman coded with the standard luminance DC table; the all-zero AC content is coded as an EOB. It sits between the pixel source and the bit packer, emitting right-aligned variable-length code words.

## Interface
- `IMG_WIDTH`, default 64: pixels per line.
- `IMG_HEIGHT`, default 64: lines per frame. `IMG_WIDTH*IMG_HEIGHT` must be a multiple of 64.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  frame start pulse.
- `R`, `G`, `B`  in  8 each  pixel components, unsigned.
- `out_code`  out  16  code word, right-aligned; bit `out_len-1` is sent first; bits at and above `out_len` are 0.
- `out_len`  out  4  valid bit count, 2..14.
- `out_valid`  out  1  `out_code`/`out_len` valid this cycle.
- `img_done`  out  1  sticky frame-complete flag.

## Operation
- States:
  - IDLE: pixels are ignored.
  - RUN: entered at the edge that samples `start`=1. That edge does not sample a pixel. One pixel is sampled at every following edge until `IMG_WIDTH*IMG_HEIGHT` pixels have been taken, then the block returns to IDLE.
  - There is no per-pixel valid input.
- Luma: Y = (77R + 150G + 29B) >> 8. Truncating; result is 0..255.
- Block sum: S = Σ(Y−128) over the 64 pixels, signed, 14 bits, range −8192..8128. Pixels are grouped strictly in arrival order; there is no raster-to-block reordering.
- DC = S >>> 6 (arithmetic shift: divide by 8 for DCT scaling, then quantize by 8). Range −128..127.
- diff = DC − pred. `pred` is cleared to 0 at `start` and at reset, and is set to DC after each block. diff is 9-bit signed.
- cat = bit length of |diff|; cat = 0 when diff = 0.
- Amplitude bits: the low `cat` bits of diff when diff > 0; the low `cat` bits of (diff−1) when diff < 0.
- DC Huffman codes (luminance, by cat):
  - 0 → 00
  - 1 → 010
  - 2 → 011
  - 3 → 100
  - 4 → 101
  - 5 → 110
  - 6 → 1110
  - 7 → 11110
  - 8 → 111110
- Per block, two words are emitted in consecutive cycles:
  - DC word: {huffman, amplitude}, `out_len` = codelen + cat.
  - EOB word: `out_code`=0x000A, `out_len`=4.
- `img_done` is set with the last block's EOB word. It is cleared by `start` or reset.
- `start` while in RUN restarts the frame: counters and `pred` are cleared, and pending pipeline outputs are discarded (no words emitted for the partial block).

## Timing
- Reset values: `out_code`=0, `out_len`=0, `out_valid`=0, `img_done`=0, state IDLE, `pred`=0, accumulator=0.
- Pipeline, with the 64th pixel of a block sampled at edge N:
  - N+1: Y registered.
  - N+2: accumulation complete.
  - N+3: DC word registered, `out_valid`=1.
  - N+4: EOB word registered, `out_valid`=1.
  - N+5: `out_valid`=0 unless another block is due.
- Blocks are ≥64 cycles apart, so output words never collide.
- `out_code`/`out_len` hold their last value when `out_valid`=0.
- For the last block, `img_done` rises at N+4 together with the EOB word.
- The accumulator clears at the start of each block; there is no wrap between blocks.
- Reset asserted mid-frame: all state returns to reset values immediately; a new `start` is required.

## Test plan
- Constant R=AA, G=BB, B=CC, 64×64 frame (Y=183, DC=55):
  - First block: 0x03B7/len 10, then 0x000A/len 4.
  - Next 63 blocks: 0x0000/len 2, then 0x000A/len 4.
  - 128 words in total; `img_done` rises with the last word and stays high.
- All pixels 0,0,0 (DC=−128): first DC word 0x3E7F/len 14.
- All pixels 255,255,255 (DC=127): first DC word 0x0F7F/len 12.
- All pixels 128,128,128: every DC word is 0x0000/len 2.
- Alternating black and white blocks: second block diff=+255 → 0x3EFF/len 14; third block diff=−255 → 0x3E00/len 14.
- Mid-frame cases:
  - `start` re-pulse after 100 pixels: no words for the partial block; the next block uses pred=0.
  - `rst_n` low mid-frame: all outputs return to 0 and `img_done` stays 0.
